fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - MIPS instruction field ranges used by the jump predecoder
//   - opcode constant for j
//   - helper for the prefetch queue entry width ({inst, pc_plus_4})
package fetch_unit_pkg;

    // Instruction field ranges
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned J_ADDR_MSB = 25;
    localparam int unsigned J_ADDR_LSB = 0;

    // Opcode of the unconditional jump (j)
    localparam logic [5:0] OP_J = 6'b000010;

    // Queue entry holds the instruction and its PC + 4
    function automatic int unsigned entry_width(input int unsigned inst_w,
                                                input int unsigned addr_w);
        return inst_w + addr_w;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Parametrised circular prefetch buffer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail (caller guarantees space)
//   push_data    entry to enqueue
//   pop          drop the head entry (ignored when empty)
//   clear        empty the queue; overrides push and pop in the same cycle
//   count        number of stored entries, 0..DEPTH
//   head         head entry, read straight from the storage registers
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear;
    assign do_pop  = pop && (count_q != '0) && !clear;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end for the 5-stage MIPS pipeline.
// Keeps up to DEPTH requests in flight, buffers in-order responses in a
// prefetch queue and hands them to ID over a valid/ready handshake. A
// redirect flushes the queue and discards responses of stale requests.
// Optional build macro FETCH_PREDECODE_JUMP_EN: predecode j in the response
// path and redirect fetch to its target without waiting for EX/MEM.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     one request per cycle while credits remain
//   imem_rvalid/rdata in-order responses, latency >= 1
//   id_valid/ready    head handshake towards ID
//   id_inst           head instruction
//   id_pc_plus_4      head PC + 4
//   redirect_valid/pc flush and refetch from redirect_pc
//   inflight          outstanding request count
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INST_W-1:0]      imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INST_W-1:0]      id_inst,
    output logic [ADDR_W-1:0]      id_pc_plus_4,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] inflight
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = entry_width(INST_W, ADDR_W);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   count;
    logic [SUM_W-1:0]   credits_used;
    logic [ADDR_W-1:0]  resp_pc_plus_4;
    logic [ENTRY_W-1:0] head;
    logic               rsp_accept;
    logic               jump_taken;
    logic               issue;

    assign resp_pc_plus_4 = resp_pc_q + ADDR_W'(4);

    // A response is kept only when it belongs to the current path.
    assign rsp_accept = imem_rvalid && !redirect_valid && (discard_q == '0);

`ifdef FETCH_PREDECODE_JUMP_EN
    logic [ADDR_W-1:0] jump_target;

    assign jump_taken  = rsp_accept && (imem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_J);
    assign jump_target = {resp_pc_plus_4[ADDR_W-1:28],
                          imem_rdata[J_ADDR_MSB:J_ADDR_LSB], 2'b00};
`else
    assign jump_taken = 1'b0;
`endif

    // Queued entries plus outstanding requests never exceed DEPTH, so every
    // response has a slot waiting for it.
    assign credits_used = SUM_W'(count) + SUM_W'(inflight_q);
    assign issue        = !redirect_valid && !jump_taken && (credits_used < SUM_W'(DEPTH));

    // Gated by rst_n so the strobe is quiet while reset is held.
    assign imem_req  = rst_n && issue;
    assign imem_addr = fetch_pc_q;
    assign inflight  = inflight_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        // Stale requests keep their credit until their response returns.
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(imem_rvalid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = inflight_q - CNT_W'(imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_plus_4;
                end
            end
`ifdef FETCH_PREDECODE_JUMP_EN
            // The jump itself is enqueued; everything still in flight behind
            // it is on the wrong path.
            if (jump_taken) begin
                fetch_pc_d = jump_target;
                resp_pc_d  = jump_target;
                discard_d  = inflight_q - CNT_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_accept),
        .push_data ({imem_rdata, resp_pc_plus_4}),
        .pop       (id_valid && id_ready),
        .clear     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign id_valid     = (count != '0);
    assign id_inst      = head[ENTRY_W-1:ADDR_W];
    assign id_pc_plus_4 = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable
// latency and a path-level reference model of which fetched PCs must reach ID.
module tb_fetch_unit;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clk            = 1'b0;
    logic                   rst_n          = 1'b1;
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_rvalid    = 1'b0;
    logic [31:0]            imem_rdata     = '0;
    logic                   id_valid;
    logic                   id_ready       = 1'b0;
    logic [31:0]            id_inst;
    logic [31:0]            id_pc_plus_4;
    logic                   redirect_valid = 1'b0;
    logic [31:0]            redirect_pc    = '0;
    logic [$clog2(DEPTH):0] inflight;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc_plus_4   (id_pc_plus_4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inflight       (inflight)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          sb_errs  = 0;
    string       sb_msg   = "";
    int unsigned lat      = 1;
    int unsigned cyc      = 0;
    int          hs_count = 0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];
    bit          pend_live[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = RESET_PC;
    bit          jump_en_tb = 1'b0;
    logic [31:0] jump_at    = '0;
    logic [31:0] jump_word  = '0;

    // Per-cycle observations for the directed tests
    logic        o_req, o_valid, o_hs;
    logic [31:0] o_addr, o_pc4;
    logic [2:0]  o_inflight;

    // Program image: never a j unless the jump test plants one.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jump_en_tb && a == jump_at) return jump_word;
        return {6'b001000, a[27:2] ^ 26'h15A5A5A};
    endfunction

    task automatic model_clear();
        pend_addr.delete();
        pend_due.delete();
        pend_live.delete();
        exp_q.delete();
        exp_fetch = RESET_PC;
    endtask

    // One clock: drive inputs, observe, advance the model across the edge.
    task automatic cycle(input bit ready, input bit redir, input logic [31:0] rpc);
        bit          rv;
        bit          rlive;
        logic [31:0] ra;
        logic [31:0] w;
        logic [31:0] ra4;
        id_ready       = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rv             = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_addr[0]) : $urandom;
        #1;
        o_req      = imem_req;
        o_addr     = imem_addr;
        o_valid    = id_valid;
        o_pc4      = id_pc_plus_4;
        o_inflight = inflight;
        o_hs       = id_valid && ready;
        if (int'(inflight) != pend_addr.size()) begin
            sb_errs++;
            sb_msg = $sformatf("cyc %0d inflight %0d model %0d", cyc, inflight,
                               pend_addr.size());
        end
        if (imem_req && redir) begin
            sb_errs++;
            sb_msg = $sformatf("cyc %0d request during redirect", cyc);
        end
        if (imem_req && imem_addr !== exp_fetch) begin
            sb_errs++;
            sb_msg = $sformatf("cyc %0d addr %h model %h", cyc, imem_addr, exp_fetch);
        end
        if (o_hs && !redir) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                sb_errs++;
                sb_msg = $sformatf("cyc %0d unexpected head pc4 %h", cyc, id_pc_plus_4);
            end else begin
                if (id_pc_plus_4 !== exp_q[0] + 32'd4 || id_inst !== mem_word(exp_q[0])) begin
                    sb_errs++;
                    sb_msg = $sformatf("cyc %0d head %h/%h model %h/%h", cyc, id_pc_plus_4,
                                       id_inst, exp_q[0] + 32'd4, mem_word(exp_q[0]));
                end
                void'(exp_q.pop_front());
            end
        end
        if (rv) begin
            ra = pend_addr.pop_front();
            void'(pend_due.pop_front());
            rlive = pend_live.pop_front();
            if (!redir && rlive) begin
                exp_q.push_back(ra);
`ifdef FETCH_PREDECODE_JUMP_EN
                w   = mem_word(ra);
                ra4 = ra + 32'd4;
                if (w[31:26] == 6'b000010) begin
                    foreach (pend_live[i]) pend_live[i] = 1'b0;
                    exp_fetch = {ra4[31:28], w[25:0], 2'b00};
                    if (imem_req) begin
                        sb_errs++;
                        sb_msg = $sformatf("cyc %0d request beside predecoded jump", cyc);
                    end
                end
`else
                w   = '0;
                ra4 = '0;
`endif
            end
        end
        if (redir) begin
            foreach (pend_live[i]) pend_live[i] = 1'b0;
            exp_q.delete();
            exp_fetch = rpc;
        end
        if (imem_req) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            pend_live.push_back(1'b1);
            exp_fetch = exp_fetch + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Memory is drained (model cleared) while reset is held.
    task automatic reset_dut();
        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || inflight !== 3'd0) begin
            fails++;
            $display("FAIL reset_ctrl: req=%b valid=%b inflight=%0d, required 0/0/0",
                     imem_req, id_valid, inflight);
        end
        tests++;
        if (imem_addr !== RESET_PC) begin
            fails++;
            $display("FAIL reset_addr: got %h required %h", imem_addr, RESET_PC);
        end
        tests++;
        if (id_inst !== 32'd0 || id_pc_plus_4 !== 32'd0) begin
            fails++;
            $display("FAIL reset_head: inst=%h pc4=%h, required 0/0", id_inst, id_pc_plus_4);
        end
        reset_dut();
    endtask

    task automatic test_stream();
        int e0;
        reset_dut();
        lat = 1;
        e0  = sb_errs;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, '0);
            tests++;
            if (o_req !== 1'b1 || o_addr !== 32'(4 * k)) begin
                fails++;
                $display("FAIL stream_addr[%0d]: req=%b addr=%h, required req=1 addr=%h",
                         k, o_req, o_addr, 32'(4 * k));
            end
            tests++;
            if (k < 2) begin
                if (o_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_early[%0d]: valid=%b required 0", k, o_valid);
                end
            end else if (o_valid !== 1'b1 || o_pc4 !== 32'(4 * (k - 1))) begin
                fails++;
                $display("FAIL stream_head[%0d]: valid=%b pc4=%h, required 1/%h",
                         k, o_valid, o_pc4, 32'(4 * (k - 1)));
            end
        end
        tests++;
        if (sb_errs != e0) begin
            fails++;
            $display("FAIL stream_model: errors=%0d required 0 (%s)", sb_errs - e0, sb_msg);
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        bit found = 1'b0;
        reset_dut();
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, '0);
            if (o_req) reqs++;
        end
        tests++;
        if (reqs != 4 || o_req !== 1'b0) begin
            fails++;
            $display("FAIL bp_requests: issued=%0d last_req=%b, required 4/0", reqs, o_req);
        end
        tests++;
        if (o_valid !== 1'b1 || o_pc4 !== 32'h4 || o_inflight !== 3'd0) begin
            fails++;
            $display("FAIL bp_hold: valid=%b pc4=%h inflight=%0d, required 1/4/0",
                     o_valid, o_pc4, o_inflight);
        end
        cycle(1'b1, 1'b0, '0);
        for (int k = 0; k < 4 && !found; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (o_req) found = 1'b1;
        end
        tests++;
        if (!found || o_addr !== 32'h10) begin
            fails++;
            $display("FAIL bp_resume: found=%0d addr=%h, required 1/00000010", found, o_addr);
        end
    endtask

    task automatic test_redirect_drop();
        int e0;
        bit hit = 1'b0;
        bit seen = 1'b0;
        int wrong = 0;
        logic [31:0] first = '0;
        reset_dut();
        lat = 3;
        e0  = sb_errs;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (inflight == 3'd3) hit = 1'b1;
            else cycle(1'b1, 1'b0, '0);
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rd_inflight3: inflight=%0d never reached required 3", inflight);
        end
        cycle(1'b1, 1'b1, 32'h100);
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (o_valid && !seen) begin
                seen  = 1'b1;
                first = o_pc4;
            end
            if (o_valid && o_pc4 >= 32'h10 && o_pc4 <= 32'h18) wrong++;
        end
        tests++;
        if (!seen || first !== 32'h104) begin
            fails++;
            $display("FAIL rd_first_head: seen=%0d pc4=%h, required 1/00000104", seen, first);
        end
        tests++;
        if (wrong != 0) begin
            fails++;
            $display("FAIL rd_wrong_path: heads=%0d required 0", wrong);
        end
        tests++;
        if (sb_errs != e0) begin
            fails++;
            $display("FAIL rd_model: errors=%0d required 0 (%s)", sb_errs - e0, sb_msg);
        end
    endtask

    task automatic test_redirect_handshake();
        int e0;
        bit found = 1'b0;
        logic [31:0] rpc;
        reset_dut();
        lat = $urandom_range(1, 3);
        e0  = sb_errs;
        rpc = 32'h1000 + ($urandom_range(0, 255) << 2);
        for (int k = 0; k < 200 && !found; k++) begin
            if (id_valid && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                cycle(1'b1, 1'b1, rpc);
                found = 1'b1;
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'b0, '0);
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rh_setup: no handshake+response cycle, required one");
        end
        cycle(1'b1, 1'b0, '0);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL rh_flush: valid=%b required 0", o_valid);
        end
        for (int k = 0; k < 20; k++) cycle(1'($urandom_range(0, 1)), 1'b0, '0);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, '0);
        tests++;
        if (o_req !== 1'b1) begin
            fails++;
            $display("FAIL rh_credit: req=%b required 1 when streaming", o_req);
        end
        tests++;
        if (sb_errs != e0) begin
            fails++;
            $display("FAIL rh_model: errors=%0d required 0 (%s)", sb_errs - e0, sb_msg);
        end
    endtask

    task automatic test_random();
        int e0;
        int h0;
        reset_dut();
        e0 = sb_errs;
        h0 = hs_count;
        for (int s = 0; s < 6; s++) begin
            lat = $urandom_range(1, 4);
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 24) == 0) begin
                    cycle(1'($urandom_range(0, 1)), 1'b1,
                          32'h2000 + ($urandom_range(0, 1023) << 2));
                end else begin
                    cycle($urandom_range(0, 9) < 7, 1'b0, '0);
                end
            end
        end
        tests++;
        if (sb_errs != e0) begin
            fails++;
            $display("FAIL random_model: errors=%0d required 0 (%s)", sb_errs - e0, sb_msg);
        end
        tests++;
        if (hs_count - h0 < 100) begin
            fails++;
            $display("FAIL random_progress: handshakes=%0d required >=100", hs_count - h0);
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        logic [31:0] first = '0;
        reset_dut();
        lat = 2;
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, '0);
        #2 rst_n = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || inflight !== 3'd0) begin
            fails++;
            $display("FAIL areset_ctrl: req=%b valid=%b inflight=%0d, required 0/0/0",
                     imem_req, id_valid, inflight);
        end
        tests++;
        if (imem_addr !== RESET_PC || id_inst !== 32'd0 || id_pc_plus_4 !== 32'd0) begin
            fails++;
            $display("FAIL areset_data: addr=%h inst=%h pc4=%h, required %h/0/0",
                     imem_addr, id_inst, id_pc_plus_4, RESET_PC);
        end
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, '0);
        tests++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            fails++;
            $display("FAIL areset_resume: req=%b addr=%h, required 1/%h", o_req, o_addr, RESET_PC);
        end
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (o_valid) begin
                seen  = 1'b1;
                first = o_pc4;
            end
        end
        tests++;
        if (!seen || first !== 32'h4) begin
            fails++;
            $display("FAIL areset_head: seen=%0d pc4=%h, required 1/00000004", seen, first);
        end
    endtask

    task automatic test_jump();
        int e0;
        logic [31:0] seq[$];
        logic [31:0] want;
`ifdef FETCH_PREDECODE_JUMP_EN
        want = 32'h44;
`else
        want = 32'h10;
`endif
        reset_dut();
        jump_en_tb = 1'b1;
        jump_at    = 32'h8;
        jump_word  = {6'b000010, 26'h10};
        lat        = 2;
        e0         = sb_errs;
        for (int k = 0; k < 30 && seq.size() < 4; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (o_hs) seq.push_back(o_pc4);
        end
        tests++;
        if (seq.size() < 4) begin
            fails++;
            $display("FAIL jump_count: heads=%0d required 4", seq.size());
        end else begin
            tests++;
            if (seq[0] !== 32'h4 || seq[1] !== 32'h8 || seq[2] !== 32'hC) begin
                fails++;
                $display("FAIL jump_prefix: %h %h %h, required 4 8 c", seq[0], seq[1], seq[2]);
            end
            tests++;
            if (seq[3] !== want) begin
                fails++;
                $display("FAIL jump_next: pc4=%h required %h", seq[3], want);
            end
        end
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, '0);
        tests++;
        if (sb_errs != e0) begin
            fails++;
            $display("FAIL jump_model: errors=%0d required 0 (%s)", sb_errs - e0, sb_msg);
        end
        jump_en_tb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_handshake();
        test_random();
        test_async_reset();
        test_jump();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
